// File: rtl/rx_protocol_if.sv
// Byte-receive and register-write bus between the FT245 receive path, the frame
// decoder and the configuration register bank.
interface rx_protocol_if #(
    parameter int RX_WIDTH   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [RX_WIDTH-1:0]   rx_data;
    logic                  rx_rdy;
    logic                  rx_ack;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_data;
    logic                  reg_rdy;
    logic                  reg_ack;
    logic                  timeout_err;
    logic [15:0]           frame_cnt;

    modport slave (
        input  rx_data, rx_rdy, reg_ack,
        output rx_ack, reg_addr, reg_data, reg_rdy, timeout_err, frame_cnt
    );

    modport master (
        output rx_data, rx_rdy, reg_ack,
        input  rx_ack, reg_addr, reg_data, reg_rdy, timeout_err, frame_cnt
    );
endinterface

// File: rtl/rx_protocol.sv
// Decodes 3-byte command frames (address, data MSB, data LSB) from the receive
// byte stream into register-write transactions, with an inter-byte timeout.
module rx_protocol #(
    parameter int RX_WIDTH       = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    rx_protocol_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ADDR,
        ST_DATA_H,
        ST_DATA_L,
        ST_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rdy_q, rdy_d;
    logic                  terr_q, terr_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]      to_q, to_d;
    logic                  accepting;
    logic                  xfer;

    // ST_OUT is the only state that refuses bytes; that is the backpressure.
    assign accepting  = (state_q != ST_OUT);
    assign bus.rx_ack = bus.rx_rdy & accepting & ~rst;
    assign xfer       = bus.rx_rdy & accepting;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdy_d       = rdy_q;
        terr_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        to_d        = to_q;

        case (state_q)
            ST_ADDR: begin
                to_d = '0;
                if (xfer) begin
                    addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                    state_d = ST_DATA_H;
                end
            end
            ST_DATA_H, ST_DATA_L: begin
                if (xfer) begin
                    to_d = '0;
                    if (state_q == ST_DATA_H) begin
                        data_d  = {bus.rx_data, data_q[RX_WIDTH-1:0]};
                        state_d = ST_DATA_L;
                    end else begin
                        data_d  = {data_q[DATA_WIDTH-1 -: RX_WIDTH], bus.rx_data};
                        rdy_d   = 1'b1;
                        state_d = ST_OUT;
                    end
                end else if (to_q == TO_LAST) begin
                    // Truncated frame: drop it, keep the stale register values.
                    to_d    = '0;
                    terr_d  = 1'b1;
                    state_d = ST_ADDR;
                end else begin
                    to_d = to_q + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.reg_ack) begin
                    rdy_d       = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    to_d        = '0;
                    state_d     = ST_ADDR;
                end
            end
            default: state_d = ST_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ADDR;
            addr_q      <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            terr_q      <= 1'b0;
            frame_cnt_q <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            terr_q      <= terr_d;
            frame_cnt_q <= frame_cnt_d;
            to_q        <= to_d;
        end
    end

    assign bus.reg_addr    = addr_q;
    assign bus.reg_data    = data_q;
    assign bus.reg_rdy     = rdy_q;
    assign bus.timeout_err = terr_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_rx_protocol.sv
// Scoreboard bench for rx_protocol: a frame-level reference model predicts each
// cycle's outputs and completed writes; a separate monitor compares them.
module tb_rx_protocol;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_protocol_if #(.RX_WIDTH(8), .ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    rx_protocol #(
        .RX_WIDTH(8), .ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        known;
        logic        rx_ack;
        logic        reg_rdy;
        logic        terr;
        logic [15:0] cnt;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    exp_t expq[$];
    wr_t  wrq[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes of the frame collected so far, a completed frame
    // waiting for the bank, and the count of idle cycles since the last byte.
    logic [7:0]  partial[$];
    bit          m_known = 0;
    bit          m_pend  = 0;
    int          m_idle  = 0;
    bit          m_terr  = 0;
    logic [15:0] m_cnt   = 16'd0;
    logic [7:0]  m_wa    = 8'd0;
    logic [15:0] m_wd    = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit rdy, input logic [7:0] d, input bit ack);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.rx_rdy  = rdy;
        bus.rx_data = d;
        bus.reg_ack = ack;

        e.known   = m_known;
        e.rx_ack  = rdy && !m_pend && !r;
        e.reg_rdy = m_pend;
        e.terr    = m_terr;
        e.cnt     = m_cnt;
        e.addr    = m_wa;
        e.data    = m_wd;
        expq.push_back(e);

        m_terr = 0;
        if (r) begin
            partial.delete();
            m_pend  = 0;
            m_idle  = 0;
            m_cnt   = 16'd0;
            m_known = 1;
        end else if (m_pend) begin
            if (ack) begin
                wrq.push_back('{addr: m_wa, data: m_wd});
                m_pend = 0;
                m_cnt  = m_cnt + 16'd1;
            end
        end else if (rdy) begin
            partial.push_back(d);
            m_idle = 0;
            if (partial.size() == 3) begin
                m_wa   = partial[0];
                m_wd   = {partial[1], partial[2]};
                m_pend = 1;
                partial.delete();
            end
        end else if (partial.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                partial.delete();
                m_idle = 0;
                m_terr = 1;
            end
        end
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, ack);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
        cycle(0, 1, a, 1);
        cycle(0, 1, h, 1);
        cycle(0, 1, l, 1);
    endtask

    // Monitor: compares whatever the DUT shows against what the model queued.
    initial begin
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                if (e.known) begin
                    chk("rx_ack", 32'(bus.rx_ack), 32'(e.rx_ack));
                    chk("reg_rdy", 32'(bus.reg_rdy), 32'(e.reg_rdy));
                    chk("timeout_err", 32'(bus.timeout_err), 32'(e.terr));
                    chk("frame_cnt", 32'(bus.frame_cnt), 32'(e.cnt));
                    if (e.reg_rdy) begin
                        chk("held_addr", 32'(bus.reg_addr), 32'(e.addr));
                        chk("held_data", 32'(bus.reg_data), 32'(e.data));
                    end
                end
            end
            if (bus.reg_rdy === 1'b1 && bus.reg_ack === 1'b1 && rst === 1'b0) begin
                if (wrq.size() == 0) begin
                    chk("unexpected_write", 32'(bus.reg_addr), 32'hFFFF_FFFF);
                end else begin
                    w = wrq.pop_front();
                    chk("write_addr", 32'(bus.reg_addr), 32'(w.addr));
                    chk("write_data", 32'(bus.reg_data), 32'(w.data));
                end
            end
        end
    end

    initial begin
        int gap;
        bit rdy;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.reg_ack = 1'b0;

        // Reset, then a full-rate frame with the bank always accepting.
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        idle(2, 1);
        frame(8'h05, 8'h12, 8'h34);
        idle(3, 1);

        // Backpressure: bank stalls while the next address byte waits.
        cycle(0, 1, 8'h05, 0);
        cycle(0, 1, 8'h12, 0);
        cycle(0, 1, 8'h34, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 8'h07, 0);
        cycle(0, 1, 8'h07, 1);
        cycle(0, 1, 8'h07, 0);
        cycle(0, 1, 8'h00, 0);
        cycle(0, 1, 8'h01, 0);
        idle(1, 1);
        idle(2, 0);

        // Truncated frame times out, then a clean frame.
        cycle(0, 1, 8'h03, 1);
        cycle(0, 1, 8'hAB, 1);
        idle(10, 1);
        frame(8'h09, 8'h00, 8'h01);
        idle(3, 1);

        // Byte arriving in the would-be timeout cycle wins.
        cycle(0, 1, 8'h03, 1);
        idle(TO - 1, 1);
        cycle(0, 1, 8'hAB, 1);
        cycle(0, 1, 8'hCD, 1);
        idle(3, 1);

        // Reset mid-frame discards it.
        cycle(0, 1, 8'h55, 1);
        cycle(0, 1, 8'h66, 1);
        cycle(1, 0, 8'h00, 1);
        frame(8'h01, 8'hFF, 8'hFE);
        idle(3, 1);

        // Frame counter wrap: preload 16'hFFFF, then deliver one frame.
        idle(1, 1);
        force dut.frame_cnt_d = 16'hFFFF;
        m_cnt = 16'hFFFF;
        idle(1, 1);
        release dut.frame_cnt_d;
        frame(8'h42, 8'h13, 8'h37);
        idle(3, 1);

        // Randomized traffic with idle gaps, stalls and occasional resets.
        gap = 0;
        for (int i = 0; i < 800; i++) begin
            if (gap > 0) begin
                rdy = 0;
                gap--;
            end else if ($urandom % 25 == 0) begin
                gap = $urandom_range(4, 12);
                rdy = 0;
            end else begin
                rdy = ($urandom % 4) != 0;
            end
            cycle(($urandom % 150) == 0, rdy, 8'($urandom), ($urandom % 3) != 0);
        end

        idle(4, 1);
        @(negedge clk);
        #4;
        chk("writes_outstanding", 32'(wrq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
